// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding,
// keyboard command/scan constants and clock filter length.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RTS,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  localparam logic [7:0] CMD_BREAK    = 8'hF0;
  localparam logic [7:0] CMD_ACK      = 8'hFA;
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_KB_RESET = 8'hFF;
  localparam logic [7:0] CMD_ECHO     = 8'hEE;

  localparam int FILTER_LEN = 8;

  // Data is held low for this many cycles at the end of the inhibit.
  localparam int RTS_DATA_CYCLES = 16;

endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock de-glitcher: the filtered level only moves once
// FILTER_LEN consecutive raw samples agree.
module ps2_clk_filter
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic ps2c_i,
  output logic filt_o,
  output logic neg_edge_o
);

  logic [FILTER_LEN-1:0] shift_q, shift_d;
  logic                  filt_q, filt_d;

  always_comb begin
    shift_d = {ps2c_i, shift_q[FILTER_LEN-1:1]};
    filt_d  = filt_q;
    if (&shift_q) begin
      filt_d = 1'b1;
    end else if (~|shift_q) begin
      filt_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q <= '0;
      filt_q  <= 1'b0;
    end else begin
      shift_q <= shift_d;
      filt_q  <= filt_d;
    end
  end

  assign filt_o     = filt_q;
  assign neg_edge_o = filt_q & ~filt_d;

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, then one
// odd-parity byte clocked out by the device, with ACK capture.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_drive_low,
  output logic       ps2d_drive_low,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ?
                           INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] INH_LAST  = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] DATA_FROM =
    CW'(INHIBIT_CYCLES - RTS_DATA_CYCLES);
  localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);

  tx_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      bits_q, bits_d;
  logic [8:0]      frame_q, frame_d;
  logic            err_q, err_d;
  logic            done_q, done_d;
  logic            filt;
  logic            neg_edge;
  logic            timeout;

  ps2_clk_filter u_filt (
    .clk        (clk),
    .reset      (reset),
    .ps2c_i     (ps2c_in),
    .filt_o     (filt),
    .neg_edge_o (neg_edge)
  );

  assign timeout = (cnt_q == TO_LAST);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bits_d  = bits_q;
    frame_d = frame_q;
    err_d   = err_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (wr_ps2) begin
          state_d = ST_RTS;
          frame_d = {~^din, din};
          err_d   = 1'b0;
        end
      end
      ST_RTS: begin
        if (cnt_q == INH_LAST) begin
          state_d = ST_START;
          cnt_d   = '0;
        end
      end
      ST_START: begin
        if (neg_edge) begin
          state_d = ST_DATA;
          bits_d  = 4'd8;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_DATA: begin
        if (neg_edge) begin
          cnt_d = '0;
          if (bits_q == 4'd0) begin
            state_d = ST_STOP;
          end else begin
            frame_d = frame_q >> 1;
            bits_d  = bits_q - 4'd1;
          end
        end else if (timeout) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_STOP: begin
        // Device pulls data low on the 11th edge to acknowledge.
        if (neg_edge) begin
          state_d = ST_IDLE;
          err_d   = ps2d_in;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else if (timeout) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bits_q  <= '0;
      frame_q <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bits_q  <= bits_d;
      frame_q <= frame_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    ps2d_drive_low = 1'b0;
    unique case (state_q)
      ST_RTS:   ps2d_drive_low = (cnt_q >= DATA_FROM);
      ST_START: ps2d_drive_low = 1'b1;
      ST_DATA:  ps2d_drive_low = ~frame_q[0];
      default:  ps2d_drive_low = 1'b0;
    endcase
  end

  assign ps2c_drive_low = (state_q == ST_RTS);
  assign tx_idle        = (state_q == ST_IDLE);
  assign tx_done_tick   = done_q;
  assign tx_err         = err_q;

  logic unused_filt;
  assign unused_filt = filt;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx with an open-drain keyboard model
// that clocks frames and acknowledges or refuses them.
module tb_ps2_tx;

  localparam int INH = 5000;
  localparam int TO  = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_ps2 = 1'b0;
  logic [7:0] din = 8'h00;
  logic       ps2c_in, ps2d_in;
  logic       ps2c_drive_low, ps2d_drive_low;
  logic       tx_idle, tx_done_tick, tx_err;
  logic       dev_c_low = 1'b0;
  logic       dev_d_low = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  assign ps2c_in = ~(ps2c_drive_low | dev_c_low);
  assign ps2d_in = ~(ps2d_drive_low | dev_d_low);

  always #10 clk = ~clk;

  always @(negedge clk)
    if (tx_done_tick === 1'b1) done_cnt <= done_cnt + 1;

  ps2_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_ps2         (wr_ps2),
    .din            (din),
    .ps2c_in        (ps2c_in),
    .ps2d_in        (ps2d_in),
    .ps2c_drive_low (ps2c_drive_low),
    .ps2d_drive_low (ps2d_drive_low),
    .tx_idle        (tx_idle),
    .tx_done_tick   (tx_done_tick),
    .tx_err         (tx_err)
  );

  typedef struct {
    logic [7:0]  din;
    logic        ack;
    logic [10:0] bits;
    logic        err;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  // Request a frame and follow the inhibit until the clock is let go.
  task automatic start_frame(input logic [7:0] d);
    int n;
    logic d_before;
    @(negedge clk);
    din = d;
    wr_ps2 = 1'b1;
    @(negedge clk);
    wr_ps2 = 1'b0;
    din = 8'h5A;
    check("accept_idle", 32'(tx_idle), 32'd0);
    check("accept_cdrv", 32'(ps2c_drive_low), 32'd1);
    check("accept_err", 32'(tx_err), 32'd0);
    check("rts_early_d", 32'(ps2d_drive_low), 32'd0);
    n = 1;
    d_before = 1'b0;
    while (ps2c_drive_low === 1'b1 && n < INH + 100) begin
      d_before = ps2d_drive_low;
      @(negedge clk);
      if (ps2c_drive_low === 1'b1) n++;
    end
    check("inhibit_len", 32'(n), 32'(INH));
    check("rts_d_low", 32'(d_before), 32'd1);
    check("start_d_low", 32'(ps2d_drive_low), 32'd1);
  endtask

  // Keyboard: 11 clock pulses, 40 clk low / 40 clk high.
  task automatic device(input logic ack, input int wr_at,
                        input int rst_at,
                        output logic [10:0] bits);
    bits = '0;
    repeat (20) @(negedge clk);
    bits[0] = ps2d_in;
    for (int n = 1; n <= 11; n++) begin
      if (n == 11) dev_d_low = ack;
      dev_c_low = 1'b1;
      repeat (20) @(negedge clk);
      if (n == wr_at) begin
        din = 8'hFF;
        wr_ps2 = 1'b1;
        @(negedge clk);
        wr_ps2 = 1'b0;
      end
      if (n == rst_at) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_cdrv", 32'(ps2c_drive_low), 32'd0);
        check("rst_ddrv", 32'(ps2d_drive_low), 32'd0);
        check("rst_idle", 32'(tx_idle), 32'd1);
        dev_c_low = 1'b0;
        return;
      end
      repeat (20) @(negedge clk);
      if (n <= 10) bits[n] = ps2d_in;
      dev_c_low = 1'b0;
      repeat (40) @(negedge clk);
      dev_d_low = 1'b0;
    end
  endtask

  task automatic end_checks(input int done0, input logic err);
    check("done_once", 32'(done_cnt - done0), 32'd1);
    check("end_idle", 32'(tx_idle), 32'd1);
    check("end_err", 32'(tx_err), 32'(err));
    check("end_cdrv", 32'(ps2c_drive_low), 32'd0);
    check("end_ddrv", 32'(ps2d_drive_low), 32'd0);
  endtask

  initial begin
    logic [10:0] bits;
    int d0;
    int k;

    vecs[0] = '{8'hED, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0}, 1'b0};
    vecs[1] = '{8'h00, 1'b1, {1'b1, 1'b1, 8'h00, 1'b0}, 1'b0};
    vecs[2] = '{8'hFA, 1'b0, {1'b1, 1'b1, 8'hFA, 1'b0}, 1'b1};
    vecs[3] = '{8'h01, 1'b1, {1'b1, 1'b0, 8'h01, 1'b0}, 1'b0};
    vecs[4] = '{8'hF0, 1'b1, {1'b1, 1'b1, 8'hF0, 1'b0}, 1'b0};

    repeat (2) @(negedge clk);
    check("rst_idle0", 32'(tx_idle), 32'd1);
    check("rst_cdrv0", 32'(ps2c_drive_low), 32'd0);
    check("rst_ddrv0", 32'(ps2d_drive_low), 32'd0);
    check("rst_done0", 32'(tx_done_tick), 32'd0);
    check("rst_err0", 32'(tx_err), 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      d0 = done_cnt;
      start_frame(vecs[i].din);
      device(vecs[i].ack, 0, 0, bits);
      check($sformatf("bits_%0d", i), 32'(bits),
            32'(vecs[i].bits));
      end_checks(d0, vecs[i].err);
    end

    // Write of 8'hFF during data must not disturb the frame.
    d0 = done_cnt;
    start_frame(8'h3C);
    device(1'b1, 4, 0, bits);
    check("busy_bits", 32'(bits),
          32'({1'b1, 1'b1, 8'h3C, 1'b0}));
    end_checks(d0, 1'b0);

    // Reset at edge 5 aborts silently.
    d0 = done_cnt;
    start_frame(8'hA5);
    device(1'b1, 0, 5, bits);
    repeat (100) @(negedge clk);
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    check("rst_idle_l", 32'(tx_idle), 32'd1);
    d0 = done_cnt;
    start_frame(8'h12);
    device(1'b1, 0, 0, bits);
    check("post_rst_bits", 32'(bits),
          32'({1'b1, 1'b1, 8'h12, 1'b0}));
    end_checks(d0, 1'b0);

    // Silent device: timeout after TO cycles of start.
    d0 = done_cnt;
    start_frame(8'h55);
    k = 0;
    while (tx_done_tick !== 1'b1 && k < 3 * TO) begin
      @(negedge clk);
      k++;
    end
    check("timeout_len", 32'(k), 32'(TO));
    @(negedge clk);
    end_checks(d0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
